control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  start request, sampled in IDLE.
- opcode  in  3  instruction opcode from the datapath.
- zero_ac  in  1  accumulator-zero flag from the datapath.
- dm_ack  in  1  data-memory completion, valid while dm_rd or dm_wr is high.
- step  in  1  single-step pulse; present only with CTRL_SINGLE_STEP_EN.
- ld_ac  out  1  accumulator load enable.
- alu_op  out  1  0=add, 1=sub.
- ac_src  out  2  00=ALU, 01=memory, 10=sign-extended immediate.
- pc_src  out  2  00=PC+1, 01=immediate target, 10=hold.
- dm_rd  out  1  data-memory read request.
- dm_wr  out  1  data-memory write request.
- halted  out  1  high in HALT state.
- instr_cnt  out  16  retired-instruction counter.

Function
REQ-002 Opcode map SHALL be: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 JMP, 101 JZ, 110 LDI, 111 HLT.
REQ-003 FSM states SHALL be IDLE, FETCH, EXEC, MEM, HALT (plus PAUSE with CTRL_SINGLE_STEP_EN).
REQ-004 IDLE: all outputs at default; go to FETCH when run=1, else stay.
REQ-005 FETCH: latch opcode into op_q; go to MEM for LDA/STA/ADD/SUB, else EXEC.
REQ-006 Default outputs, driven whenever not overridden: ld_ac=0, alu_op=0, ac_src=00, pc_src=10, dm_rd=0, dm_wr=0.
REQ-007 EXEC (one cycle, then FETCH): JMP gives pc_src=01; JZ gives pc_src=01 if zero_ac=1 in that cycle, else 00; LDI gives ld_ac=1, ac_src=10, pc_src=00; HLT gives pc_src=10 and the next state is HALT.
REQ-008 MEM: dm_rd=1 for LDA/ADD/SUB and dm_wr=1 for STA, held stable until the cycle in which dm_ack=1.
REQ-009 While in MEM with dm_ack=0, pc_src SHALL be 10 and ld_ac SHALL be 0.
REQ-010 In the MEM cycle where dm_ack=1 (Mealy on dm_ack), pc_src SHALL be 00 and the next state SHALL be FETCH.
REQ-011 In that same cycle, LDA SHALL drive ld_ac=1, ac_src=01.
REQ-012 In that same cycle, ADD/SUB SHALL drive ld_ac=1, ac_src=00, alu_op=op_q[0].
REQ-013 In that same cycle, STA SHALL drive ld_ac=0.
REQ-014 Latency SHALL be 2 cycles for non-memory instructions and 1+N cycles for memory instructions, where N is the number of MEM cycles up to and including the dm_ack cycle.
REQ-015 instr_cnt SHALL increment by 1 in each EXEC cycle and each MEM dm_ack cycle, wrapping 0xFFFF->0x0000; HLT counts.
REQ-016 HALT SHALL be absorbing (pc_src=10, halted=1) until reset; run is ignored.
REQ-017 dm_ack outside MEM SHALL be ignored.
REQ-018 dm_rd and dm_wr SHALL never be high together.

Reset
REQ-019 reset=1 at a clock edge SHALL force IDLE, op_q=000, instr_cnt=0, halted=0, and all outputs to REQ-006 defaults, from any state including mid-MEM.
REQ-020 reset SHALL take priority over run, dm_ack and step in the same cycle.

Configuration
REQ-021 With CTRL_SINGLE_STEP_EN defined, each retirement (EXEC, or MEM with dm_ack) SHALL go to PAUSE instead of FETCH; HLT still goes to HALT.
REQ-022 PAUSE SHALL drive defaults and go to FETCH on the cycle step=1.
REQ-023 Without CTRL_SINGLE_STEP_EN, the step port and PAUSE SHALL NOT exist and retirement SHALL go directly to FETCH.

Structure
REQ-024 Opcode encodings, ac_src/pc_src encodings and the state encoding SHALL be defined in a shared package (cpu_pkg).
REQ-025 The block SHALL be a single module; the 16-bit counter MAY be the sub-module instr_counter.

Verification
REQ-026 Reset, then run=1 with LDI: FETCH then EXEC; in EXEC ld_ac=1, ac_src=10, pc_src=00; afterwards instr_cnt=1.
REQ-027 ADD with dm_ack delayed 3 cycles: dm_rd=1 for 3 cycles with pc_src=10 and ld_ac=0; in the 3rd cycle ld_ac=1, alu_op=0, pc_src=00.
REQ-028 JZ: zero_ac=1 gives pc_src=01; zero_ac=0 gives pc_src=00.
REQ-029 STA: dm_wr=1, dm_rd=0, ld_ac=0 throughout.
REQ-030 HLT: halted=1 and pc_src=10; run pulses cause no change; reset returns the block to IDLE with instr_cnt=0.
REQ-031 reset asserted mid-MEM with dm_rd=1: the next cycle is IDLE and dm_rd=0.
REQ-032 instr_cnt preset near 0xFFFF: wraps to 0x0000 on the next retirement.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared encodings for the control sequencer.
//   - opcode map, ac_src / pc_src select encodings
//   - FSM state encoding (PAUSE only reachable with CTRL_SINGLE_STEP_EN)
//   - ctrl_t: packed bundle of the datapath control outputs
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 16;

  // Opcode map
  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // Accumulator source select
  localparam logic [1:0] AC_ALU = 2'b00;
  localparam logic [1:0] AC_MEM = 2'b01;
  localparam logic [1:0] AC_IMM = 2'b10;

  // PC source select
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_TGT  = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b10;

  // FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;

  typedef struct packed {
    logic             ld_ac;
    logic             alu_op;
    logic [SEL_W-1:0] ac_src;
    logic [SEL_W-1:0] pc_src;
    logic             dm_rd;
    logic             dm_wr;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    ld_ac:  1'b0,
    alu_op: 1'b0,
    ac_src: AC_ALU,
    pc_src: PC_HOLD,
    dm_rd:  1'b0,
    dm_wr:  1'b0
  };

  // Opcodes that go through the MEM state
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/instr_counter.sv
// ---------------------------------------------------------------------------
// instr_counter: 16-bit retired-instruction counter, wraps 0xFFFF -> 0x0000.
//   clk    in   clock
//   reset  in   synchronous active-high clear
//   inc_i  in   count one retirement this cycle
//   cnt_o  out  current count
// ---------------------------------------------------------------------------
module instr_counter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Natural modulo-2^16 wrap
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer: multi-cycle accumulator-CPU control FSM.
// Optional feature macro: CTRL_SINGLE_STEP_EN (adds step port + PAUSE state;
// every retirement then waits for a step pulse before the next fetch).
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   run        in   start request, sampled in IDLE
//   opcode     in   [2:0] instruction opcode
//   zero_ac    in   accumulator-zero flag
//   dm_ack     in   data-memory completion (only observed in MEM)
//   step       in   single-step pulse (CTRL_SINGLE_STEP_EN only)
//   ld_ac      out  accumulator load enable
//   alu_op     out  0=add 1=sub
//   ac_src     out  [1:0] accumulator source select
//   pc_src     out  [1:0] PC source select
//   dm_rd      out  data-memory read request
//   dm_wr      out  data-memory write request
//   halted     out  high in HALT
//   instr_cnt  out  [15:0] retired-instruction count
// Control outputs are decoded from the state register and, in EXEC/MEM,
// from zero_ac / dm_ack in the same cycle.
// ---------------------------------------------------------------------------
module control_sequencer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero_ac,
  input  logic             dm_ack,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             ld_ac,
  output logic             alu_op,
  output logic [SEL_W-1:0] ac_src,
  output logic [SEL_W-1:0] pc_src,
  output logic             dm_rd,
  output logic             dm_wr,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  // Where a retiring instruction goes next
`ifdef CTRL_SINGLE_STEP_EN
  localparam logic [2:0] S_RETIRE = S_PAUSE;
`else
  localparam logic [2:0] S_RETIRE = S_FETCH;
`endif

  logic [ST_W-1:0] state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            retire;
  ctrl_t           ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LDA;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    ctrl    = CTRL_DEFAULT;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        op_d    = opcode;
        state_d = is_mem_op(opcode) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        retire  = 1'b1;
        state_d = S_RETIRE;
        case (op_q)
          OP_JMP: ctrl.pc_src = PC_TGT;
          OP_JZ:  ctrl.pc_src = zero_ac ? PC_TGT : PC_INC;
          OP_LDI: begin
            ctrl.ld_ac  = 1'b1;
            ctrl.ac_src = AC_IMM;
            ctrl.pc_src = PC_INC;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        // Request held until ack; STA is the only writer
        ctrl.dm_rd = (op_q != OP_STA);
        ctrl.dm_wr = (op_q == OP_STA);
        if (dm_ack) begin
          retire      = 1'b1;
          state_d     = S_RETIRE;
          ctrl.pc_src = PC_INC;
          case (op_q)
            OP_LDA: begin
              ctrl.ld_ac  = 1'b1;
              ctrl.ac_src = AC_MEM;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ld_ac  = 1'b1;
              ctrl.ac_src = AC_ALU;
              ctrl.alu_op = op_q[0];
            end
            default: ;
          endcase
        end
      end
      S_HALT: ;
`ifdef CTRL_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  instr_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (retire),
    .cnt_o (instr_cnt)
  );

  assign ld_ac  = ctrl.ld_ac;
  assign alu_op = ctrl.alu_op;
  assign ac_src = ctrl.ac_src;
  assign pc_src = ctrl.pc_src;
  assign dm_rd  = ctrl.dm_rd;
  assign dm_wr  = ctrl.dm_wr;
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer: directed, scoreboard-based bench for the default
// build. Inputs are driven on the falling edge; expected output vectors are
// queued at drive time and compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_control_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run, zero_ac, dm_ack;
  logic [2:0]  opcode;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step;
`endif
  logic        ld_ac, alu_op, dm_rd, dm_wr, halted;
  logic [1:0]  ac_src, pc_src;
  logic [15:0] instr_cnt;

  int checks   = 0;
  int failures = 0;

  logic [24:0] sb_q[$];
  string       tag_q[$];
  logic [15:0] cnt_m;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .zero_ac   (zero_ac),
    .dm_ack    (dm_ack),
`ifdef CTRL_SINGLE_STEP_EN
    .step      (step),
`endif
    .ld_ac     (ld_ac),
    .alu_op    (alu_op),
    .ac_src    (ac_src),
    .pc_src    (pc_src),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  // Expected vector: {ld, alu, ac_src, pc_src, rd, wr, halted, cnt}
  function automatic logic [24:0] ev(input logic ld, input logic alu,
                                     input logic [1:0] acs, input logic [1:0] pcs,
                                     input logic rd, input logic wr, input logic h);
    return {ld, alu, acs, pcs, rd, wr, h, cnt_m};
  endfunction

  // One clock cycle: drive at negedge, queue expectation, compare, move on
  task automatic cyc(input string tag, input logic rst, input logic r,
                     input logic [2:0] op, input logic z, input logic ack,
                     input logic [24:0] e);
    logic [24:0] obs;
    logic [24:0] exp_v;
    string       t;
    reset   = rst;
    run     = r;
    opcode  = op;
    zero_ac = z;
    dm_ack  = ack;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    obs   = {ld_ac, alu_op, ac_src, pc_src, dm_rd, dm_wr, halted, instr_cnt};
    exp_v = sb_q.pop_front();
    t     = tag_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp_v);
    end
    checks++;
    assert (!(dm_rd === 1'b1 && dm_wr === 1'b1)) else begin
      failures++;
      $error("FAIL %s_rdwr observed=rd%b/wr%b expected=not_both", t, dm_rd, dm_wr);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [24:0] d;
    reset   = 1'b1;
    run     = 1'b0;
    opcode  = OP_LDA;
    zero_ac = 1'b0;
    dm_ack  = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    step    = 1'b0;
`endif
    cnt_m   = 16'h0000;
    @(negedge clk);

    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // Reset state and IDLE
    cyc("idle_after_reset", 1'b0, 1'b0, OP_LDI, 1'b0, 1'b1, d);
    cyc("idle_run",         1'b0, 1'b1, OP_LDI, 1'b0, 1'b0, d);

    // LDI
    cyc("ldi_fetch", 1'b0, 1'b0, OP_LDI, 1'b0, 1'b0, d);
    cyc("ldi_exec",  1'b0, 1'b0, OP_ADD, 1'b0, 1'b0,
        ev(1'b1, 1'b0, AC_IMM, PC_INC, 1'b0, 1'b0, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // ADD, ack on the 3rd MEM cycle
    cyc("add_fetch", 1'b0, 1'b0, OP_ADD, 1'b0, 1'b0, d);
    cyc("add_mem1",  1'b0, 1'b0, OP_JMP, 1'b0, 1'b0,
        ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b1, 1'b0, 1'b0));
    cyc("add_mem2",  1'b0, 1'b1, OP_JMP, 1'b0, 1'b0,
        ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b1, 1'b0, 1'b0));
    cyc("add_mem3",  1'b0, 1'b0, OP_JMP, 1'b0, 1'b1,
        ev(1'b1, 1'b0, AC_ALU, PC_INC, 1'b1, 1'b0, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // SUB, immediate ack; opcode bus changes after fetch must not matter
    cyc("sub_fetch", 1'b0, 1'b0, OP_SUB, 1'b0, 1'b0, d);
    cyc("sub_mem",   1'b0, 1'b0, OP_JMP, 1'b0, 1'b1,
        ev(1'b1, 1'b1, AC_ALU, PC_INC, 1'b1, 1'b0, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // LDA
    cyc("lda_fetch", 1'b0, 1'b0, OP_LDA, 1'b0, 1'b0, d);
    cyc("lda_mem1",  1'b0, 1'b0, OP_LDA, 1'b0, 1'b0,
        ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b1, 1'b0, 1'b0));
    cyc("lda_mem2",  1'b0, 1'b0, OP_LDA, 1'b0, 1'b1,
        ev(1'b1, 1'b0, AC_MEM, PC_INC, 1'b1, 1'b0, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // STA
    cyc("sta_fetch", 1'b0, 1'b0, OP_STA, 1'b0, 1'b0, d);
    cyc("sta_mem1",  1'b0, 1'b0, OP_STA, 1'b0, 1'b0,
        ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b1, 1'b0));
    cyc("sta_mem2",  1'b0, 1'b0, OP_STA, 1'b0, 1'b1,
        ev(1'b0, 1'b0, AC_ALU, PC_INC, 1'b0, 1'b1, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // JZ taken; dm_ack during FETCH is ignored
    cyc("jz1_fetch", 1'b0, 1'b0, OP_JZ, 1'b0, 1'b1, d);
    cyc("jz1_exec",  1'b0, 1'b0, OP_JZ, 1'b1, 1'b1,
        ev(1'b0, 1'b0, AC_ALU, PC_TGT, 1'b0, 1'b0, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // JZ not taken
    cyc("jz0_fetch", 1'b0, 1'b0, OP_JZ, 1'b1, 1'b0, d);
    cyc("jz0_exec",  1'b0, 1'b0, OP_JZ, 1'b0, 1'b0,
        ev(1'b0, 1'b0, AC_ALU, PC_INC, 1'b0, 1'b0, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // JMP
    cyc("jmp_fetch", 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0, d);
    cyc("jmp_exec",  1'b0, 1'b0, OP_JMP, 1'b0, 1'b0,
        ev(1'b0, 1'b0, AC_ALU, PC_TGT, 1'b0, 1'b0, 1'b0));
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // Reset mid-MEM: reset wins over the simultaneous dm_ack
    cyc("rst_lda_fetch", 1'b0, 1'b0, OP_LDA, 1'b0, 1'b0, d);
    cyc("rst_lda_mem1",  1'b0, 1'b0, OP_LDA, 1'b0, 1'b0,
        ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b1, 1'b0, 1'b0));
    cyc("rst_lda_mem2",  1'b1, 1'b1, OP_LDA, 1'b0, 1'b1,
        ev(1'b1, 1'b0, AC_MEM, PC_INC, 1'b1, 1'b0, 1'b0));
    cnt_m = 16'h0000;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);
    cyc("rst_idle",      1'b0, 1'b0, OP_LDA, 1'b0, 1'b0, d);
    cyc("rst_idle_run",  1'b0, 1'b1, OP_LDI, 1'b0, 1'b0, d);

    // Counter wrap: preset to 0xFFFF while in FETCH
    force dut.u_cnt.cnt_q = 16'hFFFF;
    #1;
    release dut.u_cnt.cnt_q;
    cnt_m = 16'hFFFF;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);
    cyc("wrap_fetch", 1'b0, 1'b0, OP_LDI, 1'b0, 1'b0, d);
    cyc("wrap_exec",  1'b0, 1'b0, OP_LDI, 1'b0, 1'b0,
        ev(1'b1, 1'b0, AC_IMM, PC_INC, 1'b0, 1'b0, 1'b0));
    cnt_m = 16'h0000;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);

    // HLT, then absorbing HALT
    cyc("hlt_fetch", 1'b0, 1'b0, OP_HLT, 1'b0, 1'b0, d);
    cyc("hlt_exec",  1'b0, 1'b0, OP_HLT, 1'b0, 1'b0, d);
    cnt_m = cnt_m + 16'd1;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b1);
    cyc("halt_run1", 1'b0, 1'b1, OP_LDI, 1'b1, 1'b0, d);
    cyc("halt_ack",  1'b0, 1'b0, OP_LDA, 1'b0, 1'b1, d);
    cyc("halt_run2", 1'b0, 1'b1, OP_JMP, 1'b0, 1'b0, d);
    cyc("halt_rst",  1'b1, 1'b1, OP_JMP, 1'b0, 1'b0, d);
    cnt_m = 16'h0000;
    d = ev(1'b0, 1'b0, AC_ALU, PC_HOLD, 1'b0, 1'b0, 1'b0);
    cyc("post_halt_idle", 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0, d);
    cyc("post_halt_run",  1'b0, 1'b1, OP_JMP, 1'b0, 1'b0, d);
    cyc("post_halt_fetch", 1'b0, 1'b0, OP_JMP, 1'b0, 1'b0, d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
